mux_alusrc_reg: RTL and testbench
=================================

MUX_ALUSRC_REG -- requirements
Module: mux_alusrc

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits; SHALL be at least 17.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operands and control valid this cycle.
REQ-006 stall  input  1  hold the output register; takes priority over in_valid.
REQ-007 read_data2  input  WIDTH  register-file operand (rt).
REQ-008 extensor_sinal  input  WIDTH  immediate from the sign extender.
REQ-009 controle  input  1  ALUSrc select; 0 = read_data2, 1 = immediate path.
REQ-010 imm_mode  input  2  immediate conditioning applied only when controle=1.
REQ-011 saida_para_ALU  output  WIDTH  registered ALU B operand.
REQ-012 out_valid  output  1  saida_para_ALU holds a result captured from a valid input.

Function
REQ-013 controle=0: selected value SHALL be read_data2 unmodified; imm_mode is ignored.
REQ-014 controle=1, imm_mode=00: selected value SHALL be extensor_sinal unmodified.
REQ-015 controle=1, imm_mode=01: selected value SHALL be extensor_sinal[15:0] sign-extended to WIDTH.
REQ-016 controle=1, imm_mode=10: selected value SHALL be extensor_sinal[15:0] zero-extended to WIDTH.
REQ-017 controle=1, imm_mode=11 (LUI): selected value SHALL be extensor_sinal[15:0] placed in bits [31:16] with zeros below; for WIDTH>32, bits above 31 SHALL be zero.
REQ-018 Latency: exactly 1 clock; the result SHALL appear on the edge after in_valid=1 with stall=0.
REQ-019 in_valid=1 and stall=0: saida_para_ALU SHALL load the selected value, and out_valid SHALL be set to 1.
REQ-020 in_valid=0 and stall=0: saida_para_ALU SHALL hold its value, and out_valid SHALL be cleared to 0.
REQ-021 stall=1: saida_para_ALU and out_valid SHALL both hold, regardless of in_valid.
REQ-022 The block SHALL have no combinational path from any input to any output.
REQ-023 X or undefined select values SHALL NOT be masked; behaviour is defined only for known select inputs.

Reset
REQ-024 When rst=1 at a rising edge: saida_para_ALU SHALL become 0 and out_valid SHALL become 0.
REQ-025 Reset SHALL take priority over stall and in_valid.
REQ-026 A reset asserted while stalled SHALL discard the held value.
REQ-027 The first capture after reset SHALL occur on the first edge with rst=0, in_valid=1 and stall=0.

Structure
REQ-028 A shared package SHALL hold the imm_mode encodings IMM_PASS=00, IMM_SEXT=01, IMM_ZEXT=10 and IMM_LUI=11, plus the default WIDTH constant.
REQ-029 One combinational sub-module, alusrc_imm_cond, SHALL implement REQ-014..017; the top level adds the 2:1 select and the output register.

Verification
REQ-030 Reset: rst=1 for 2 cycles with random inputs -> saida_para_ALU=0 and out_valid=0 after each edge.
REQ-031 Select: read_data2=0x009A2177, extensor_sinal=0, in_valid=1.
- controle=1, imm_mode=00 -> output 0x00000000 one cycle later.
- Then controle=0 -> output 0x009A2177 on the next edge.
REQ-032 Immediate modes: extensor_sinal=0x0000F00F, controle=1.
- imm_mode=01 -> 0xFFFFF00F.
- imm_mode=10 -> 0x0000F00F.
- imm_mode=11 -> 0xF00F0000.
REQ-033 Stall: load 0x12345678, then stall=1 with a new input -> output holds 0x12345678 and out_valid stays 1 until stall=0.
REQ-034 Bubble: in_valid=0 after a valid capture -> out_valid=0 and data holds; rst=1 during stall -> output 0 on the next edge.

Source files
------------

// File: rtl/mux_alusrc_reg_pkg.sv
// -----------------------------------------------------------------------------
// mux_alusrc_reg_pkg
// Shared definitions for the ALUSrc operand selector:
//   - DEFAULT_WIDTH : default datapath width
//   - MIN_WIDTH     : narrowest width the immediate path supports
//   - imm_mode_e    : immediate conditioning encodings (used when controle=1)
//   - lui_place()   : helper that builds the 32-bit LUI image of a 16-bit field
// -----------------------------------------------------------------------------
package mux_alusrc_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MIN_WIDTH     = 17;
  localparam int IMM_BITS      = 16;

  typedef enum logic [1:0] {
    IMM_PASS = 2'b00,  // extensor_sinal unmodified
    IMM_SEXT = 2'b01,  // sign-extend low halfword
    IMM_ZEXT = 2'b10,  // zero-extend low halfword
    IMM_LUI  = 2'b11   // low halfword into bits [31:16], zeros below
  } imm_mode_e;

  // LUI image is always defined on 32 bits; callers truncate or zero-extend
  // it to their own datapath width.
  function automatic logic [31:0] lui_place(input logic [IMM_BITS-1:0] imm);
    return {imm, {IMM_BITS{1'b0}}};
  endfunction

endpackage : mux_alusrc_reg_pkg

// File: rtl/mux_alusrc_reg_imm_cond.sv
// -----------------------------------------------------------------------------
// alusrc_imm_cond
// Combinational immediate conditioning for the ALU B operand.
// Ports:
//   extensor_sinal [WIDTH-1:0] in  : immediate from the sign extender
//   imm_mode       [1:0]       in  : conditioning select (imm_mode_e)
//   imm_out        [WIDTH-1:0] out : conditioned immediate
// Unknown imm_mode values propagate X rather than falling back to a mode.
// -----------------------------------------------------------------------------
module alusrc_imm_cond
  import mux_alusrc_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] extensor_sinal,
  input  logic [1:0]       imm_mode,
  output logic [WIDTH-1:0] imm_out
);

  logic [IMM_BITS-1:0] imm16;
  logic [WIDTH-1:0]    sext_val;
  logic [WIDTH-1:0]    zext_val;
  logic [WIDTH-1:0]    lui_val;
  logic [31:0]         lui32;

  assign imm16    = extensor_sinal[IMM_BITS-1:0];
  assign sext_val = {{(WIDTH-IMM_BITS){imm16[IMM_BITS-1]}}, imm16};
  assign zext_val = {{(WIDTH-IMM_BITS){1'b0}}, imm16};
  assign lui32    = lui_place(imm16);

  // Fit the 32-bit LUI image to WIDTH: drop bits above WIDTH-1 on narrow
  // datapaths, zero-fill above bit 31 on wide ones.
  generate
    if (WIDTH < MIN_WIDTH) begin : g_bad_width
      $error("alusrc_imm_cond: WIDTH must be at least %0d", MIN_WIDTH);
    end else if (WIDTH == 32) begin : g_lui_eq
      assign lui_val = lui32;
    end else if (WIDTH < 32) begin : g_lui_narrow
      assign lui_val = lui32[WIDTH-1:0];
    end else begin : g_lui_wide
      assign lui_val = {{(WIDTH-32){1'b0}}, lui32};
    end
  endgenerate

  always_comb begin
    imm_out = 'x;
    case (imm_mode)
      IMM_PASS: imm_out = extensor_sinal;
      IMM_SEXT: imm_out = sext_val;
      IMM_ZEXT: imm_out = zext_val;
      IMM_LUI:  imm_out = lui_val;
      default:  imm_out = 'x;
    endcase
  end

endmodule : alusrc_imm_cond

// File: rtl/mux_alusrc_reg.sv
// -----------------------------------------------------------------------------
// mux_alusrc_reg
// Registered ALUSrc multiplexer: picks read_data2 or a conditioned immediate
// and registers it as the ALU B operand with one cycle of latency.
// Ports:
//   clk            in  : rising-edge clock
//   rst            in  : synchronous active-high reset (beats stall/in_valid)
//   in_valid       in  : operands and control valid this cycle
//   stall          in  : hold output register and out_valid
//   read_data2     in  : register-file operand (rt)
//   extensor_sinal in  : immediate from the sign extender
//   controle       in  : 0 = read_data2, 1 = conditioned immediate
//   imm_mode       in  : immediate conditioning (only when controle=1)
//   saida_para_ALU out : registered ALU B operand
//   out_valid      out : saida_para_ALU was captured from a valid input
// All outputs come straight from flops; there is no input-to-output path.
// -----------------------------------------------------------------------------
module mux_alusrc_reg
  import mux_alusrc_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] read_data2,
  input  logic [WIDTH-1:0] extensor_sinal,
  input  logic             controle,
  input  logic [1:0]       imm_mode,
  output logic [WIDTH-1:0] saida_para_ALU,
  output logic             out_valid
);

  logic [WIDTH-1:0] imm_cond;
  logic [WIDTH-1:0] sel_val;

  alusrc_imm_cond #(
    .WIDTH (WIDTH)
  ) u_imm_cond (
    .extensor_sinal (extensor_sinal),
    .imm_mode       (imm_mode),
    .imm_out        (imm_cond)
  );

  // Plain conditional so an X on controle reaches the register instead of
  // silently picking one leg.
  assign sel_val = controle ? imm_cond : read_data2;

  always_ff @(posedge clk) begin
    if (rst) begin
      saida_para_ALU <= '0;
      out_valid      <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        saida_para_ALU <= sel_val;
        out_valid      <= 1'b1;
      end else begin
        out_valid      <= 1'b0;
      end
    end
  end

endmodule : mux_alusrc_reg

// File: tb/tb_mux_alusrc_reg.sv
module tb_mux_alusrc_reg;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         stall;
  logic [W-1:0] read_data2;
  logic [W-1:0] extensor_sinal;
  logic         controle;
  logic [1:0]   imm_mode;
  logic [W-1:0] saida_para_ALU;
  logic         out_valid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mux_alusrc_reg #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .stall          (stall),
    .read_data2     (read_data2),
    .extensor_sinal (extensor_sinal),
    .controle       (controle),
    .imm_mode       (imm_mode),
    .saida_para_ALU (saida_para_ALU),
    .out_valid      (out_valid)
  );

  typedef struct {
    string        name;
    logic         rst;
    logic         in_valid;
    logic         stall;
    logic [W-1:0] rd2;
    logic [W-1:0] ext;
    logic         controle;
    logic [1:0]   imm_mode;
    logic [W-1:0] exp_data;
    logic         exp_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic r, input logic iv, input logic st,
                     input logic [W-1:0] rd2, input logic [W-1:0] ext,
                     input logic c, input logic [1:0] m,
                     input logic [W-1:0] ed, input logic ev);
    vec_t v;
    v.name = nm; v.rst = r; v.in_valid = iv; v.stall = st; v.rd2 = rd2; v.ext = ext;
    v.controle = c; v.imm_mode = m; v.exp_data = ed; v.exp_valid = ev;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic st,
                       input logic [W-1:0] rd2, input logic [W-1:0] ext,
                       input logic c, input logic [1:0] m);
    rst = r; in_valid = iv; stall = st; read_data2 = rd2;
    extensor_sinal = ext; controle = c; imm_mode = m;
  endtask

  // drive at negedge, let the posedge capture, sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   name           rst iv st rd2           ext           c  mode   exp_data      exp_v
    add("sel_imm_pass", 0, 1, 0, 32'h009A2177, 32'h00000000, 1, 2'b00, 32'h00000000, 1);
    add("sel_rd2",      0, 1, 0, 32'h009A2177, 32'h00000000, 0, 2'b00, 32'h009A2177, 1);
    add("imm_sext",     0, 1, 0, 32'h009A2177, 32'h0000F00F, 1, 2'b01, 32'hFFFFF00F, 1);
    add("imm_zext",     0, 1, 0, 32'h009A2177, 32'h0000F00F, 1, 2'b10, 32'h0000F00F, 1);
    add("imm_lui",      0, 1, 0, 32'h009A2177, 32'h0000F00F, 1, 2'b11, 32'hF00F0000, 1);
    add("rd2_ign_mode", 0, 1, 0, 32'hDEADBEEF, 32'h0000F00F, 0, 2'b11, 32'hDEADBEEF, 1);
    add("pass_full",    0, 1, 0, 32'h00000000, 32'h80001234, 1, 2'b00, 32'h80001234, 1);
    add("sext_pos",     0, 1, 0, 32'h00000000, 32'hABCD7FFF, 1, 2'b01, 32'h00007FFF, 1);
    add("zext_hi_drop", 0, 1, 0, 32'h00000000, 32'hFFFF8001, 1, 2'b10, 32'h00008001, 1);
    add("lui_hi_drop",  0, 1, 0, 32'h00000000, 32'h1234ABCD, 1, 2'b11, 32'hABCD0000, 1);
    add("load",         0, 1, 0, 32'h12345678, 32'h0, 0, 2'b00, 32'h12345678, 1);
    add("stall_new_in", 0, 1, 1, 32'hAAAAAAAA, 32'h0, 0, 2'b00, 32'h12345678, 1);
    add("stall_no_in",  0, 0, 1, 32'hBBBBBBBB, 32'h0, 0, 2'b00, 32'h12345678, 1);
    add("unstall",      0, 1, 0, 32'h55555555, 32'h0, 0, 2'b00, 32'h55555555, 1);
    add("bubble",       0, 0, 0, 32'h00000000, 32'h0, 0, 2'b00, 32'h55555555, 0);
    add("stall_hold_v0",0, 1, 1, 32'h00000001, 32'h0, 0, 2'b00, 32'h55555555, 0);
    add("bubble2",      0, 0, 0, 32'h00000002, 32'h0, 0, 2'b00, 32'h55555555, 0);
    add("rst_in_stall", 1, 1, 1, 32'h00000003, 32'h0, 0, 2'b00, 32'h00000000, 0);
    add("first_cap",    0, 1, 0, 32'h00000077, 32'h0, 0, 2'b00, 32'h00000077, 1);
    add("rst_over_iv",  1, 1, 0, 32'h00000099, 32'h0, 0, 2'b00, 32'h00000000, 0);

    drive(1, 0, 0, '0, '0, 0, 2'b00);
    @(negedge clk);

    // reset with random inputs for two edges
    for (int i = 0; i < 2; i++) begin
      drive(1, 1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
            1'($urandom), 2'($urandom));
      step();
      check($sformatf("reset%0d_data", i), saida_para_ALU, '0);
      check($sformatf("reset%0d_valid", i), W'(out_valid), '0);
      @(negedge clk);
    end

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].in_valid, vecs[i].stall, vecs[i].rd2,
            vecs[i].ext, vecs[i].controle, vecs[i].imm_mode);
      step();
      check({vecs[i].name, "_data"}, saida_para_ALU, vecs[i].exp_data);
      check({vecs[i].name, "_valid"}, W'(out_valid), W'(vecs[i].exp_valid));
      @(negedge clk);
    end

    // no combinational path: changing inputs between edges leaves outputs alone
    drive(0, 1, 0, 32'hCAFEF00D, '0, 0, 2'b00);
    step();
    @(negedge clk);
    drive(0, 1, 0, 32'h0BADC0DE, 32'h0000FFFF, 1, 2'b01);
    #2;
    check("no_comb_data", saida_para_ALU, 32'hCAFEF00D);
    check("no_comb_valid", W'(out_valid), 32'h1);
    step();
    check("after_comb_data", saida_para_ALU, 32'hFFFFFFFF);

    // long stall with a loaded value, then reset while stalled discards it
    @(negedge clk);
    drive(0, 1, 0, 32'h12345678, '0, 0, 2'b00);
    step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, W'(32'h1000 + i), '0, 0, 2'b00);
      step();
      check($sformatf("long_stall%0d_data", i), saida_para_ALU, 32'h12345678);
      check($sformatf("long_stall%0d_valid", i), W'(out_valid), 32'h1);
      @(negedge clk);
    end
    drive(1, 1, 1, 32'h77777777, '0, 0, 2'b00);
    step();
    check("rst_stall_data", saida_para_ALU, '0);
    check("rst_stall_valid", W'(out_valid), '0);
    @(negedge clk);
    // still stalled after reset: hold the reset value
    drive(0, 1, 1, 32'h88888888, '0, 0, 2'b00);
    step();
    check("post_rst_stall_data", saida_para_ALU, '0);
    check("post_rst_stall_valid", W'(out_valid), '0);
    @(negedge clk);
    drive(0, 1, 0, 32'h88888888, '0, 0, 2'b00);
    step();
    check("post_rst_cap_data", saida_para_ALU, 32'h88888888);
    check("post_rst_cap_valid", W'(out_valid), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mux_alusrc_reg
